// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and helpers for the adder_arbiter slice.
//   arb_state_e : response register occupancy (EMPTY / FULL)
//   MAX_REQ     : largest supported requester count
//   idx_next()  : wrapping increment used for the round-robin pointer
package adder_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  // (ptr + 1) mod n, written as a compare so no divider is inferred.
  function automatic int unsigned idx_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/adder32.sv
// adder32: 32-bit ripple/inferred adder with carry-in and carry-out.
//   a_i, b_i : operands
//   cin_i    : carry-in
//   sum_o    : a + b + cin modulo 2^32
//   cout_o   : 33rd bit of the sum
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin search.
//   req_i         : request vector, one bit per requester
//   ptr_i         : index where the search starts (highest priority)
//   grant_valid_o : at least one request is set
//   grant_idx_o   : first set request at or after ptr_i, wrapping at N_REQ-1
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             grant_valid_o,
  output logic [ID_W-1:0]  grant_idx_o
);

  logic [ID_W-1:0] k;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    k             = '0;
    // Walk offsets 0..N_REQ-1 from ptr; the first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      k = ID_W'((int'(ptr_i) + i) % N_REQ);
      if (!grant_valid_o && req_i[k]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder32 among N_REQ requesters, round-robin,
// with a single registered response slot tagged by requester ID.
//   CLK100, resetn          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o : per-requester handshake (ready is one-hot or 0)
//   req_a_i/req_b_i         : packed operands, requester k at [32k+31:32k]
//   req_carry_i             : per-requester carry-in
//   resp_valid_o/ready_i    : response handshake
//   resp_id_o/sum_o/carry_o : registered result and its origin
// Optional: define ADDER_ARB_OVF_EN to add resp_ovf_o (signed overflow,
// registered alongside the sum).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               CLK100,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*32-1:0] req_a_i,
  input  logic [N_REQ*32-1:0] req_b_i,
  input  logic [N_REQ-1:0]   req_carry_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [ID_W-1:0]    resp_id_o,
  output logic [31:0]        resp_sum_o,
`ifdef ADDER_ARB_OVF_EN
  output logic               resp_ovf_o,
`endif
  output logic               resp_carry_o
);

  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_n_req
    $error("adder_arbiter: N_REQ out of range");
  end

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     sum_q, sum_d;
  logic            carry_q, carry_d;

  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  logic            slot_free;
  logic            accept;

  logic [31:0]     a_arr [N_REQ];
  logic [31:0]     b_arr [N_REQ];
  logic [31:0]     a_sel, b_sel, add_sum;
  logic            cin_sel, add_cout;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a_i[32*gi +: 32];
    assign b_arr[gi] = req_b_i[32*gi +: 32];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i         (req_valid_i),
    .ptr_i         (ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Operand mux: the adder always sees the current grant's operands; the
  // result is only captured when that grant completes its handshake.
  assign a_sel   = a_arr[grant_idx];
  assign b_sel   = b_arr[grant_idx];
  assign cin_sel = req_carry_i[grant_idx];

  adder32 u_add (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .cin_i  (cin_sel),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // resp_ready_i feeds straight through to req_ready_o so a drain and a new
  // accept can share one cycle. resetn gates ready while reset is held.
  assign slot_free = (state_q == EMPTY) || resp_ready_i;
  assign accept    = resetn && slot_free && grant_valid;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (accept) begin
      state_d = FULL;
      ptr_d   = ID_W'(idx_next(32'(grant_idx), N_REQ));
      id_d    = grant_idx;
      sum_d   = add_sum;
      carry_d = add_cout;
    end else if (state_q == FULL && resp_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK100 or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign resp_valid_o = (state_q == FULL);
  assign resp_id_o    = id_q;
  assign resp_sum_o   = sum_q;
  assign resp_carry_o = carry_q;

`ifdef ADDER_ARB_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept) ovf_d = (a_sel[31] == b_sel[31]) && (add_sum[31] != a_sel[31]);
  end

  always_ff @(posedge CLK100 or negedge resetn) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign resp_ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed bench with a response scoreboard for adder_arbiter.
module tb_adder_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]  req_carry;
  logic          resp_valid, resp_ready;
  logic [1:0]    resp_id;
  logic [31:0]   resp_sum;
  logic          resp_carry;
`ifdef ADDER_ARB_OVF_EN
  logic          resp_ovf;
`endif

  adder_arbiter #(.N_REQ(N)) dut (
    .CLK100       (clk),
    .resetn       (resetn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_carry_i  (req_carry),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_sum_o   (resp_sum),
`ifdef ADDER_ARB_OVF_EN
    .resp_ovf_o   (resp_ovf),
`endif
    .resp_carry_o (resp_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         m_ptr = 0;
  logic       m_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_carry[k]      = c;
  endtask

  // One clock: checks at the negedge against the model, then advances to
  // 1 time unit after the next posedge where the caller may change inputs.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic [32:0]  full_sum;
    logic [31:0]  a, b;
    int           g;
    exp_t         e;
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'(m_full));
    if (m_full && sb.size() > 0) begin
      e = sb[0];
      check("resp_id", 32'(resp_id), 32'(e.id));
      check("resp_sum", resp_sum, e.sum);
      check("resp_carry", 32'(resp_carry), 32'(e.carry));
`ifdef ADDER_ARB_OVF_EN
      check("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
`endif
    end
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    exp_ready = '0;
    if (resetn && g >= 0 && (!m_full || resp_ready)) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_full && resp_ready && sb.size() > 0) begin
      e = sb.pop_front();
      $display("resp id=%0d sum=%h carry=%0d", e.id, e.sum, e.carry);
    end
    if (exp_ready != '0) begin
      a        = req_a[32*g +: 32];
      b        = req_b[32*g +: 32];
      full_sum = {1'b0, a} + {1'b0, b} + 33'(req_carry[g]);
      e.id     = 2'(g);
      e.sum    = full_sum[31:0];
      e.carry  = full_sum[32];
      e.ovf    = (a[31] == b[31]) && (full_sum[31] != a[31]);
      sb.push_back(e);
      m_ptr  = (g + 1) % N;
      m_full = 1'b1;
      $display("accept id=%0d a=%h b=%h cin=%0d", g, a, b, req_carry[g]);
    end else if (m_full && resp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_carry  = '0;
    resp_ready = 1'b1;

    // Reset state, with a request pending that must not be readied.
    set_req(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    req_valid = 4'b0001;
    cycle();
    check("rst_sum", resp_sum, 32'h0);
    check("rst_id", 32'(resp_id), 32'h0);
    check("rst_carry", 32'(resp_carry), 32'h0);
    resetn = 1'b1;

    // Single request on requester 0.
    cycle();
    req_valid = '0;
    check("t1_sum", resp_sum, 32'h0000_0100);
    check("t1_id", 32'(resp_id), 32'd0);
    check("t1_valid", 32'(resp_valid), 32'd1);
    cycle();

    // Wrap with carry on requester 2.
    set_req(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    check("t2_sum", resp_sum, 32'h0);
    check("t2_carry", 32'(resp_carry), 32'd1);
    check("t2_id", 32'(resp_id), 32'd2);
    cycle();

    // Signed overflow on requester 3 (also moves the pointer back to 0).
    set_req(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    check("t3_sum", resp_sum, 32'h8000_0000);
    check("t3_carry", 32'(resp_carry), 32'd0);
`ifdef ADDER_ARB_OVF_EN
    check("t3_ovf", 32'(resp_ovf), 32'd1);
`endif
    cycle();

    // All requesters valid: grants 0,1,2,3,0,1 back to back.
    for (int k = 0; k < N; k++)
      set_req(k, 32'h1000_0000 * (k + 1), 32'h0000_0011 * (k + 3), k[0]);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_id", 32'(resp_id), 32'(i % N));
      check("rr_valid", 32'(resp_valid), 32'd1);
    end

    // Backpressure with requesters 1 and 3 pending.
    req_valid  = 4'b1010;
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    resp_ready = 1'b1;
    cycle();
    check("bp_id", 32'(resp_id), 32'd3);
    cycle();
    check("bp_id2", 32'(resp_id), 32'd1);
    req_valid = '0;
    cycle();

    // Asynchronous reset while FULL, then re-arbitrate from pointer 0.
    set_req(2, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
    req_valid  = 4'b0100;
    cycle();
    resp_ready = 1'b0;
    req_valid  = '0;
    resetn     = 1'b0;
    #2;
    check("arst_valid", 32'(resp_valid), 32'd0);
    check("arst_sum", resp_sum, 32'h0);
    sb.delete();
    m_full    = 1'b0;
    m_ptr     = 0;
    req_valid = 4'b1010;
    check("arst_ready", 32'(req_ready), 32'd0);
    #1;
    resetn     = 1'b1;
    resp_ready = 1'b1;
    cycle();
    check("post_rst_id", 32'(resp_id), 32'd1);
    req_valid = 4'b1000;
    cycle();
    check("post_rst_id3", 32'(resp_id), 32'd3);
    req_valid = '0;
    cycle();
    cycle();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one `adder32` instance among N_REQ requesters using valid/ready handshakes.
- Arbitration is round-robin. Each accepted operation produces one registered response, tagged with the requester ID, on a single response channel.
- Sits between the lab's bus-side clients (CPU stub, switch/button front-end, display formatter) and the adder datapath.
- Throughput is one operation per cycle when the response side is not stalled.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the response ID field (derived; not overridable).

Ports:
- CLK100  in  1  system clock.
- resetn  in  1  reset; one clock, asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester operation valid.
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  N_REQ*32  operand A, requester k at bits [32k+31:32k].
- req_b_i  in  N_REQ*32  operand B, same packing.
- req_carry_i  in  N_REQ  carry-in per requester.
- resp_valid_o  out  1  response register holds a result.
- resp_ready_i  in  1  consumer accepts the response.
- resp_id_o  out  ID_W  index of the requester that issued the result.
- resp_sum_o  out  32  sum from `adder32`.
- resp_carry_o  out  1  carry-out from `adder32`.

Behaviour:
- Reset values (asynchronous, resetn=0): resp_valid_o=0, resp_id_o=0, resp_sum_o=0, resp_carry_o=0, rr pointer=0, state=EMPTY. req_ready_o=0 while resetn=0.
- States: EMPTY (no result held) and FULL (result held).
- slot_free = (state==EMPTY) || resp_ready_i. This is a combinational path from resp_ready_i to req_ready_o.
- Grant selection: the first k with req_valid_i[k]=1, searching from ptr upward and wrapping from N_REQ-1 to 0. The search is combinational every cycle.
- req_ready_o[g] = slot_free && a grant exists. All other bits are 0.
- Handshake on requester g: req_valid_i[g] && req_ready_o[g]. On that edge:
  - The adder is fed from requester g's operands.
  - resp_sum_o/resp_carry_o/resp_id_o are registered and resp_valid_o becomes 1.
  - ptr is set to (g+1) mod N_REQ.
- Latency: request accepted at edge t gives resp_valid_o=1 after edge t. There is no combinational path from req_* to resp_*.
- Response completes when resp_valid_o && resp_ready_i. With no new grant in the same cycle, state goes to EMPTY and resp_valid_o=0. Data outputs hold their last values.
- Simultaneous response drain and new accept in the same cycle: the new result replaces the old one and state stays FULL. There is no bubble.
- Backpressure: while FULL and resp_ready_i=0, all resp_* outputs hold stable and req_ready_o=0.
- Requester rules:
  - Requesters must hold valid and operands stable until accepted.
  - Dropping valid before acceptance is legal and simply removes that requester from arbitration.
  - The arbiter never latches state for requests that were not accepted.
- ptr is updated only on a handshake. Idle cycles do not advance it.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0,...
- Arithmetic is full 32-bit modulo 2^32. Carry-out is the 33rd bit.
- Reset asserted mid-operation drops any held result and resets ptr. A pending request is re-arbitrated from ptr=0 after reset release.

Optional Feature:
- Macro ADDER_ARB_OVF_EN.
- Defined: adds port resp_ovf_o (out, 1), the signed overflow flag, registered with the sum. It equals (a[31]==b[31]) && (sum[31]!=a[31]) for the granted operands, and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package adder_arb_pkg holds:
  - the state enum {EMPTY, FULL};
  - localparam MAX_REQ=8;
  - function idx_next(ptr, n) for the wrapping increment.
- Sub-module rr_pick: purely combinational round-robin search.
  - Inputs: req vector, ptr.
  - Outputs: grant_valid, grant_idx.
- `adder32` is instantiated unchanged inside adder_arbiter. The operand mux sits in front of it.

Test Plan:
- Reset then single request: req0 A=0x0000_00FF, B=0x0000_0001, cin=0, resp_ready=1 -> one cycle later resp_valid=1, sum=0x0000_0100, carry=0, id=0.
- Wrap/carry: req2 A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> sum=0x0000_0000, carry=1, id=2. With ADDER_ARB_OVF_EN, ovf=0.
- All four requesters valid continuously with resp_ready=1 -> ids 0,1,2,3,0,1 on consecutive cycles, one response per cycle.
- Backpressure: resp_ready=0 for 5 cycles while req1,req3 valid -> resp_* stable and req_ready=0 throughout. On release, drain and accept occur in the same cycle and the next id is 3 if the previous grant was 1.
- Overflow feature: A=0x7FFF_FFFF, B=0x0000_0001 -> sum=0x8000_0000, carry=0, ovf=1 when the macro is defined; port absent otherwise.
- Asynchronous reset mid-FULL (resetn low between edges) -> resp_valid drops to 0 immediately. After release with req3 valid, req3 is granted because ptr=0 and no lower requester is valid.
